// File: rtl/msg_evt_queue.sv
// msg_evt_queue: timestamps, severity-filters and buffers message events for a software drain stage.
// Optional build macro MSG_EVT_FATAL_RESERVE_EN reserves the last FIFO slot for FATAL events.
module msg_evt_queue #(
    parameter int DEPTH  = 16,
    parameter int SRC_W  = 4,
    parameter int CODE_W = 16,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              svrt_thold,
    input  logic                    evt_vld,
    input  logic [1:0]              evt_type,
    input  logic [1:0]              evt_svrt,
    input  logic [1:0]              evt_act,
    input  logic [SRC_W-1:0]        evt_src,
    input  logic [CODE_W-1:0]       evt_code,
    output logic                    msg_vld,
    input  logic                    msg_rdy,
    output logic [1:0]              msg_type,
    output logic [1:0]              msg_svrt,
    output logic [1:0]              msg_act,
    output logic [SRC_W-1:0]        msg_src,
    output logic [CODE_W-1:0]       msg_code,
    output logic [TS_W-1:0]         msg_ts,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        filt_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    ovf,
    output logic                    done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       ACT_EXIT   = 2'd2;
    localparam logic [1:0]       TYPE_FATAL = 2'd3;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [1:0]        typ;
        logic [1:0]        svrt;
        logic [1:0]        act;
        logic [SRC_W-1:0]  src;
        logic [CODE_W-1:0] code;
        logic [TS_W-1:0]   ts;
    } rec_t;

    state_t          state;
    rec_t            mem [DEPTH];
    rec_t            head;
    rec_t            new_rec;
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]   remain;
    logic [TS_W-1:0] ts;
    logic            pop, in_run, below, no_room, push, drop_full, do_drop, do_filt;

    assign pop    = msg_vld && msg_rdy;
    assign in_run = (state == ST_RUN);
    assign below  = (evt_svrt < svrt_thold);
`ifdef MSG_EVT_FATAL_RESERVE_EN
    assign no_room = (evt_type == TYPE_FATAL) ? (level == LVL_FULL) : (level >= LVL_FULL - LVL_ONE);
`else
    assign no_room = (level == LVL_FULL);
`endif
    assign do_filt   = evt_vld && in_run && below;
    assign drop_full = evt_vld && in_run && !below && no_room && !pop;
    assign do_drop   = (evt_vld && !in_run) || drop_full;
    assign push      = evt_vld && in_run && !below && !(no_room && !pop);

    // Records left behind the head after this cycle's pop decide whether the head reloads.
    assign remain  = level - {{AW{1'b0}}, pop};
    assign rd_nxt  = rd_ptr + {{(AW-1){1'b0}}, pop};
    assign new_rec = '{typ: evt_type, svrt: evt_svrt, act: evt_act, src: evt_src,
                       code: evt_code, ts: ts};

    assign msg_type = head.typ;
    assign msg_svrt = head.svrt;
    assign msg_act  = head.act;
    assign msg_src  = head.src;
    assign msg_code = head.code;
    assign msg_ts   = head.ts;

    // NOTE: storage array has no reset; pointers and level alone define which slots hold data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    // NOTE: all sequential state uses non-blocking assignments so same-edge reads see old values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            done     <= 1'b0;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            msg_vld  <= 1'b0;
            head     <= '0;
            filt_cnt <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            if (push && !pop)      level <= level + LVL_ONE;
            else if (pop && !push) level <= level - LVL_ONE;

            // Head only advances when empty or consumed, so it is stable under backpressure.
            if (!msg_vld || pop) begin
                if (remain != '0) begin
                    msg_vld <= 1'b1;
                    head    <= mem[rd_nxt];
                end else begin
                    msg_vld <= 1'b0;
                end
            end

            if (do_filt && filt_cnt != CNT_MAX) filt_cnt <= filt_cnt + CNT_ONE;
            if (do_drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
            if (drop_full) ovf <= 1'b1;

            unique case (state)
                ST_RUN: begin
                    if (push && evt_act == ACT_EXIT) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (level == '0 && !msg_vld) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: done <= 1'b1;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_evt_queue.sv
// tb_msg_evt_queue: directed vector table plus hand sequences for fill, full-with-pop, EXIT and FATAL reserve.
module tb_msg_evt_queue;
    localparam int DEPTH  = 16;
    localparam int SRC_W  = 4;
    localparam int CODE_W = 16;
    localparam int TS_W   = 32;
    localparam int CNT_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [1:0]             svrt_thold = '0;
    logic                   evt_vld = 1'b0;
    logic [1:0]             evt_type = '0, evt_svrt = '0, evt_act = '0;
    logic [SRC_W-1:0]       evt_src = '0;
    logic [CODE_W-1:0]      evt_code = '0;
    logic                   msg_vld, msg_rdy = 1'b0;
    logic [1:0]             msg_type, msg_svrt, msg_act;
    logic [SRC_W-1:0]       msg_src;
    logic [CODE_W-1:0]      msg_code;
    logic [TS_W-1:0]        msg_ts;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       filt_cnt, drop_cnt;
    logic                   ovf, done;

    msg_evt_queue #(.DEPTH(DEPTH), .SRC_W(SRC_W), .CODE_W(CODE_W), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .svrt_thold(svrt_thold),
        .evt_vld(evt_vld), .evt_type(evt_type), .evt_svrt(evt_svrt), .evt_act(evt_act),
        .evt_src(evt_src), .evt_code(evt_code),
        .msg_vld(msg_vld), .msg_rdy(msg_rdy), .msg_type(msg_type), .msg_svrt(msg_svrt),
        .msg_act(msg_act), .msg_src(msg_src), .msg_code(msg_code), .msg_ts(msg_ts),
        .level(level), .filt_cnt(filt_cnt), .drop_cnt(drop_cnt), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  thold;
        logic        vld;
        logic [1:0]  typ, svrt, act;
        logic [15:0] code;
        logic        rdy;
        logic        e_vld;
        logic [15:0] e_code;
        int          e_level, e_filt, e_drop;
        logic        e_ovf, e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] th, input logic v,
                                input logic [1:0] ty, input logic [1:0] sv, input logic [1:0] ac,
                                input logic [15:0] cd, input logic rd, input logic ev,
                                input logic [15:0] ec, input int el, input int ef, input int ed,
                                input logic eo, input logic edn);
        vec_t t;
        t.rst = r; t.thold = th; t.vld = v; t.typ = ty; t.svrt = sv; t.act = ac;
        t.code = cd; t.rdy = rd; t.e_vld = ev; t.e_code = ec; t.e_level = el;
        t.e_filt = ef; t.e_drop = ed; t.e_ovf = eo; t.e_done = edn;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reset is sampled on one rising edge; on return the bench sits at the negedge of the ts=0 cycle.
    task automatic do_reset();
        rst_n = 1'b0; evt_vld = 1'b0; msg_rdy = 1'b0; svrt_thold = 2'd0; evt_src = 4'h1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] ty, input logic [1:0] sv, input logic [1:0] ac,
                        input logic [15:0] cd);
        evt_vld = 1'b1; evt_type = ty; evt_svrt = sv; evt_act = ac; evt_code = cd;
        @(negedge clk);
        evt_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Single event at ts=5, one-cycle output latency, then pop.
        do_reset();
        check("rst level", level, 0);
        check("rst msg_vld", msg_vld, 0);
        check("rst filt", filt_cnt, 0);
        check("rst drop", drop_cnt, 0);
        check("rst ovf", ovf, 0);
        check("rst done", done, 0);
        check("rst msg_ts", msg_ts, 0);
        repeat (5) @(negedge clk);
        evt_src = 4'd3;
        send(2'd1, 2'd1, 2'd0, 16'h00AB);
        evt_src = 4'h1;
        check("t1 level after push", level, 1);
        check("t1 msg_vld after push", msg_vld, 0);
        @(negedge clk);
        check("t1 msg_vld", msg_vld, 1);
        check("t1 msg_ts", msg_ts, 5);
        check("t1 msg_type", msg_type, 1);
        check("t1 msg_svrt", msg_svrt, 1);
        check("t1 msg_act", msg_act, 0);
        check("t1 msg_src", msg_src, 3);
        check("t1 msg_code", msg_code, 16'h00AB);
        msg_rdy = 1'b1;
        @(negedge clk);
        msg_rdy = 1'b0;
        check("t1 level after pop", level, 0);
        check("t1 msg_vld after pop", msg_vld, 0);

        // Cycle-accurate table: threshold filter, per-cycle threshold, EXIT drain, reset, filtered EXIT.
        //           rst th vld ty sv ac code    rdy  e_vld e_code  lvl filt drop ovf done
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 0, 0, 16'h10, 0, 0, 16'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 1, 0, 16'h11, 0, 0, 16'h00, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 2, 0, 16'h12, 0, 0, 16'h00, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 3, 0, 16'h13, 0, 1, 16'h12, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 16'h00, 1, 1, 16'h13, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 16'h00, 1, 0, 16'h00, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 3, 1, 0, 2, 0, 16'h14, 0, 0, 16'h00, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h15, 0, 0, 16'h00, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 0, 1, 16'h15, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h21, 0, 0, 16'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 2, 3, 2, 16'h22, 0, 1, 16'h21, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h23, 0, 1, 16'h21, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 1, 1, 16'h22, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 16'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h24, 0, 0, 16'h00, 0, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 1, 0, 0, 2, 16'h30, 0, 0, 16'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h31, 0, 0, 16'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 1, 1, 16'h31, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 16'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 16'h00, 0, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = !vecs[i].rst; svrt_thold = vecs[i].thold; evt_vld = vecs[i].vld;
            evt_type = vecs[i].typ; evt_svrt = vecs[i].svrt; evt_act = vecs[i].act;
            evt_code = vecs[i].code; msg_rdy = vecs[i].rdy; evt_src = 4'h1;
            @(negedge clk);
            check($sformatf("vec%0d msg_vld", i), msg_vld, vecs[i].e_vld);
            if (vecs[i].e_vld) check($sformatf("vec%0d msg_code", i), msg_code, vecs[i].e_code);
            check($sformatf("vec%0d level", i), level, vecs[i].e_level);
            check($sformatf("vec%0d filt_cnt", i), filt_cnt, vecs[i].e_filt);
            check($sformatf("vec%0d drop_cnt", i), drop_cnt, vecs[i].e_drop);
            check($sformatf("vec%0d ovf", i), ovf, vecs[i].e_ovf);
            check($sformatf("vec%0d done", i), done, vecs[i].e_done);
        end
        evt_vld = 1'b0; msg_rdy = 1'b0; rst_n = 1'b1;

        // Overfill: 20 events into 16 slots, then drain in order with ts 0..15.
        do_reset();
        for (int i = 0; i < 20; i++) send(2'd0, 2'd0, 2'd0, 16'h0100 + 16'(i));
        check("fill level", level, 16);
        check("fill drop_cnt", drop_cnt, 4);
        check("fill ovf", ovf, 1);
        check("fill msg_vld", msg_vld, 1);
        msg_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d msg_vld", i), msg_vld, 1);
            check($sformatf("drain%0d msg_code", i), msg_code, 16'h0100 + 16'(i));
            check($sformatf("drain%0d msg_ts", i), msg_ts, i);
            @(negedge clk);
        end
        msg_rdy = 1'b0;
        check("drain level", level, 0);
        check("drain msg_vld", msg_vld, 0);
        check("drain ovf sticky", ovf, 1);

        // Full queue with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) send(2'd0, 2'd0, 2'd0, 16'h0200 + 16'(i));
        check("fullpp level before", level, 16);
        msg_rdy = 1'b1;
        send(2'd0, 2'd0, 2'd0, 16'h02FF);
        msg_rdy = 1'b0;
        check("fullpp level", level, 16);
        check("fullpp drop_cnt", drop_cnt, 0);
        check("fullpp ovf", ovf, 0);
        check("fullpp head", msg_code, 16'h0201);
        msg_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullpp rec%0d", i), msg_code,
                  (i < 15) ? 16'h0201 + 16'(i) : 16'h02FF);
            @(negedge clk);
        end
        msg_rdy = 1'b0;
        check("fullpp level after", level, 0);

        // Last-slot behaviour: 16 INFO then 1 FATAL.
        do_reset();
        for (int i = 0; i < 16; i++) send(2'd0, 2'd0, 2'd0, 16'h0300 + 16'(i));
        send(2'd3, 2'd3, 2'd0, 16'h03FF);
        check("rsv level", level, 16);
        check("rsv drop_cnt", drop_cnt, 1);
        check("rsv ovf", ovf, 1);
        msg_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef MSG_EVT_FATAL_RESERVE_EN
            check($sformatf("rsv rec%0d", i), msg_code, (i < 15) ? 16'h0300 + 16'(i) : 16'h03FF);
            if (i == 15) check("rsv last type", msg_type, 3);
`else
            check($sformatf("rsv rec%0d", i), msg_code, 16'h0300 + 16'(i));
            if (i == 15) check("rsv last type", msg_type, 0);
`endif
            @(negedge clk);
        end
        msg_rdy = 1'b0;
        check("rsv level after", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msg_evt_queue.md
Name: msg_evt_queue

Overview:
- Hardware-side collector for graded message events raised by monitors or checkers inside the testbench harness.
- Timestamps each event, filters it by a runtime severity threshold and buffers it in a FIFO, so the software print/log stage can drain records at its own pace.
- Counts dropped events and handles EXIT-action events by draining the queue and then signalling completion.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- SRC_W, 4, source-ID width.
- CODE_W, 16, message-code width.
- TS_W, 32, timestamp counter width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- svrt_thold  in  2  severity threshold: 0 LOW, 1 MEDIUM, 2 HIGH, 3 HIGHEST.
- evt_vld  in  1  event strobe; no backpressure is applied to the producer.
- evt_type  in  2  message type: 0 INFO, 1 WARN, 2 ERROR, 3 FATAL.
- evt_svrt  in  2  event severity.
- evt_act  in  2  action: 0 LOG, 1 STOP, 2 EXIT; 3 is treated as LOG.
- evt_src  in  SRC_W  source ID.
- evt_code  in  CODE_W  message code.
- msg_vld  out  1  head record valid.
- msg_rdy  in  1  consumer accepts the head record.
- msg_type, msg_svrt, msg_act  out  2 each  head record fields.
- msg_src  out  SRC_W  head record source ID.
- msg_code  out  CODE_W  head record message code.
- msg_ts  out  TS_W  timestamp captured when the event was accepted.
- level  out  $clog2(DEPTH)+1  current occupancy.
- filt_cnt  out  CNT_W  events removed by the severity filter.
- drop_cnt  out  CNT_W  events lost to a full queue or to DRAIN/DONE state.
- ovf  out  1  sticky flag: at least one event was dropped because the queue was full.
- done  out  1  high in state DONE.

Behaviour:
- Reset state: all outputs 0, state RUN, FIFO empty, timestamp counter 0.
- Timestamp counter:
  - Increments every cycle after reset and wraps modulo 2^TS_W.
  - The value sampled is the one present in the cycle evt_vld is high.
- Event classification, in priority order, in the cycle evt_vld=1:
  1. State is not RUN: drop, drop_cnt+1.
  2. evt_svrt < svrt_thold: filter, filt_cnt+1.
  3. Queue full with no pop this cycle: drop, drop_cnt+1, ovf set to 1.
  4. Otherwise: push.
- Full versus pop: if level==DEPTH and a pop occurs in the same cycle, the push is accepted and level stays at DEPTH.
- Counters: filt_cnt and drop_cnt saturate at 2^CNT_W-1 and never wrap.
- Pop: happens when msg_vld && msg_rdy.
- Output path:
  - Head fields are registered and stable while msg_vld=1 and msg_rdy=0.
  - Latency is one cycle: an event pushed into an empty queue at edge N gives msg_vld=1 after edge N+1.
  - Back-to-back pops sustain one record per cycle.
- Pointers: binary read/write pointers, log2(DEPTH) bits, wrap naturally.
- level: updates on the same edge as the push or pop; simultaneous push and pop leaves it unchanged.
- State machine:
  - RUN → DRAIN: on pushing an event with evt_act=EXIT. The EXIT record itself is queued.
  - DRAIN → DONE: when level==0 and msg_vld==0, i.e. the EXIT record has been popped.
  - DONE: held until reset; done=1.
  - Filtered or dropped EXIT events cause no transition.
- STOP: STOP-action events are buffered like LOG events. The consumer acts on msg_act; the block never stalls.
- Reset mid-operation: a synchronous rst_n=0 empties the queue, clears counters, ovf and timestamp, and returns to RUN within one edge. An in-flight msg_vld drops without handshake.
- svrt_thold: may change any cycle; the value in the event's cycle applies.

Optional Feature:
- Macro: MSG_EVT_FATAL_RESERVE_EN.
- When defined:
  - The last FIFO slot is reserved for FATAL events.
  - A non-FATAL event arriving with level>=DEPTH-1 and no simultaneous pop is dropped (drop_cnt+1, ovf=1).
  - A FATAL event can still fill slot DEPTH.
- When undefined: all types share all DEPTH slots.

Test Plan:
- Reset, svrt_thold=0, one event (type=WARN, svrt=1, src=3, code=0x00AB) at cycle 5 → msg_vld=1 one cycle after the push edge, msg_ts=5, fields match, level=1; msg_rdy=1 → level=0.
- svrt_thold=2, send events with svrt 0,1,2,3 → filt_cnt=2, only svrt 2 and 3 are queued, in order.
- msg_rdy=0, DEPTH=16, send 20 events → level=16, drop_cnt=4, ovf=1. Then drain with msg_rdy=1 → 16 records with ascending timestamps.
- Queue full; push and pop in the same cycle → push accepted, level=16, drop_cnt unchanged.
- Push LOG, EXIT, LOG → third event dropped (drop_cnt=1). After both queued records are popped, done=1 and stays 1. Then rst_n=0 for one cycle → done=0, level=0, counters=0.
- With MSG_EVT_FATAL_RESERVE_EN, msg_rdy=0, push 15 INFO then 1 INFO then 1 FATAL → 16th INFO dropped, FATAL queued, level=16, drop_cnt=1.
